// File: rtl/clkdiv_pkg.sv
// Shared constants for the clock divider family and the
// divided-clock checker that watches their outputs.
package clkdiv_pkg;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int DEF_EXP_HALF = 1;
  localparam int DEF_TOL      = 0;

  typedef enum logic [1:0] {
    HUNT   = ST_HUNT,
    TRACK  = ST_TRACK,
    LOCKED = ST_LOCKED
  } chk_state_e;

endpackage

// File: rtl/sync_ff.sv
// Flop chain for bringing an asynchronous level into the clk domain.
// Reused by every cross-domain input in the codebase.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/div_clock_checker.sv
// Measures each half-period of a divided clock in clk cycles,
// declares lock after a run of good halves, flags ratio/stuck errors.
module div_clock_checker
  import clkdiv_pkg::*;
#(
  parameter int EXP_HALF    = DEF_EXP_HALF,
  parameter int TOL         = DEF_TOL,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic             stuck,
  output logic [7:0]       err_cnt
);

  localparam int W1 = CNT_W + 1;
  localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

  localparam logic [CNT_W-1:0] RUN_MAX = '1;
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [W1-1:0]    EXP_W   = W1'(EXP_HALF);
  localparam logic [W1-1:0]    TOL_W   = W1'(TOL);
  localparam logic [W1-1:0]    HI_W    = W1'(EXP_HALF + TOL);
  localparam logic [MW-1:0]    LAST_M  = MW'(LOCK_CNT - 1);

  logic             s;
  logic             prev;
  logic             edge_det;
  logic             timeout;
  logic             good;
  logic [CNT_W-1:0] run_len;
  logic [W1-1:0]    meas;

  chk_state_e       state_q;
  chk_state_e       state_d;
  logic [MW-1:0]    match_q;
  logic [MW-1:0]    match_d;
  logic             locked_d;
  logic             stuck_d;
  logic             pv_d;
  logic             err_d;
  logic [CNT_W-1:0] hp_d;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (div_in),
    .q  (s)
  );

  assign edge_det = s ^ prev;

  // One extra bit so the low-side window test never wraps.
  assign meas = {1'b0, run_len};
  assign good = (meas + TOL_W >= EXP_W) && (meas <= HI_W);

  // A stuck HUNT stays quiet until the next edge re-arms it.
  assign timeout = !edge_det
                && (run_len == TMO)
                && !(state_q == HUNT && stuck);

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    locked_d = locked;
    stuck_d  = stuck;
    hp_d     = half_period;
    pv_d     = 1'b0;
    err_d    = 1'b0;
    unique case (1'b1)
      edge_det: begin
        unique case (state_q)
          HUNT: begin
            state_d = TRACK;
            match_d = '0;
          end
          TRACK: begin
            pv_d = 1'b1;
            hp_d = run_len;
            if (!good) begin
              err_d   = 1'b1;
              match_d = '0;
            end else if (match_q == LAST_M) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              stuck_d  = 1'b0;
              match_d  = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end
          LOCKED: begin
            pv_d = 1'b1;
            hp_d = run_len;
            if (!good) begin
              err_d    = 1'b1;
              locked_d = 1'b0;
              state_d  = TRACK;
              match_d  = '0;
            end
          end
          default: begin
            state_d = HUNT;
            match_d = '0;
          end
        endcase
      end
      timeout: begin
        err_d    = 1'b1;
        stuck_d  = 1'b1;
        locked_d = 1'b0;
        state_d  = HUNT;
        match_d  = '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev    <= 1'b0;
      run_len <= '0;
    end else begin
      prev <= s;
      if (edge_det) begin
        run_len <= CNT_W'(1);
      end else if (run_len != RUN_MAX) begin
        run_len <= run_len + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HUNT;
      match_q      <= '0;
      edge_pulse   <= 1'b0;
      half_period  <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
      stuck        <= 1'b0;
      err_cnt      <= '0;
    end else begin
      state_q      <= state_d;
      match_q      <= match_d;
      edge_pulse   <= edge_det;
      half_period  <= hp_d;
      period_valid <= pv_d;
      locked       <= locked_d;
      err          <= err_d;
      stuck        <= stuck_d;
      if (err_d && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_div_clock_checker.sv
// Bench for div_clock_checker: two instances (divide-by-2 and
// EXP_HALF=4/TOL=1) checked against a timestamp-based reference.
module tb_div_clock_checker;

  localparam int S     = 2;
  localparam int LOCKN = 4;
  localparam int TMO   = 16;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic div_in = 1'b0;

  logic       edge_o  [2];
  logic       pv_o    [2];
  logic       lock_o  [2];
  logic       err_o   [2];
  logic       stuck_o [2];
  logic [7:0] hp_o    [2];
  logic [7:0] cnt_o   [2];

  always #5 clk = ~clk;

  div_clock_checker u0 (
    .clk         (clk),
    .rst         (rst),
    .div_in      (div_in),
    .edge_pulse  (edge_o[0]),
    .half_period (hp_o[0]),
    .period_valid(pv_o[0]),
    .locked      (lock_o[0]),
    .err         (err_o[0]),
    .stuck       (stuck_o[0]),
    .err_cnt     (cnt_o[0])
  );

  div_clock_checker #(
    .EXP_HALF(4),
    .TOL     (1)
  ) u1 (
    .clk         (clk),
    .rst         (rst),
    .div_in      (div_in),
    .edge_pulse  (edge_o[1]),
    .half_period (hp_o[1]),
    .period_valid(pv_o[1]),
    .locked      (lock_o[1]),
    .err         (err_o[1]),
    .stuck       (stuck_o[1]),
    .err_cnt     (cnt_o[1])
  );

  int checks = 0;
  int errors = 0;

  // Reference: edges come from the driven history, half-periods
  // from the timestamp of the last accepted edge.
  int exp_h [2] = '{1, 4};
  int tol   [2] = '{0, 1};
  int t;
  bit hist [$];
  bit cur;
  int le      [2];
  int streak  [2];
  int m_hp    [2];
  int m_cnt   [2];
  bit hunting [2];
  bit m_lock  [2];
  bit m_stuck [2];
  bit m_edge  [2];
  bit m_pv    [2];
  bit m_err   [2];
  int diverge [2];
  string note [2];

  function automatic bit dval(input int k);
    if (k < 0 || k >= hist.size()) return 1'b0;
    return hist[k];
  endfunction

  task automatic model_reset();
    t = 0;
    hist.delete();
    for (int k = 0; k < 2; k++) begin
      le[k]      = 1;
      streak[k]  = 0;
      m_hp[k]    = 0;
      m_cnt[k]   = 0;
      hunting[k] = 1'b1;
      m_lock[k]  = 1'b0;
      m_stuck[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    int meas;
    bit ed;
    bit good;
    bit to;
    ed = dval(t - S - 1) != dval(t - S - 2);
    for (int k = 0; k < 2; k++) begin
      meas = t - le[k];
      if (meas > 255) meas = 255;
      good = (meas >= exp_h[k] - tol[k]) && (meas <= exp_h[k] + tol[k]);
      to = !ed && meas == TMO && !(hunting[k] && m_stuck[k]);
      m_edge[k] = ed;
      m_pv[k]   = 1'b0;
      m_err[k]  = 1'b0;
      if (ed) begin
        if (hunting[k]) begin
          hunting[k] = 1'b0;
          streak[k]  = 0;
        end else begin
          m_pv[k] = 1'b1;
          m_hp[k] = meas;
          if (!good) begin
            m_err[k]  = 1'b1;
            m_lock[k] = 1'b0;
            streak[k] = 0;
          end else if (!m_lock[k]) begin
            streak[k]++;
            if (streak[k] == LOCKN) begin
              m_lock[k]  = 1'b1;
              m_stuck[k] = 1'b0;
              streak[k]  = 0;
            end
          end
        end
        le[k] = t;
      end else if (to) begin
        m_err[k]   = 1'b1;
        m_stuck[k] = 1'b1;
        m_lock[k]  = 1'b0;
        hunting[k] = 1'b1;
        streak[k]  = 0;
      end
      if (m_err[k] && m_cnt[k] < 255) m_cnt[k]++;
    end
  endtask

  task automatic tick(input bit d);
    @(posedge clk);
    t++;
    model_step();
    #1;
    for (int k = 0; k < 2; k++) begin
      if (edge_o[k] !== m_edge[k] || pv_o[k] !== m_pv[k]
          || hp_o[k] !== 8'(m_hp[k]) || lock_o[k] !== m_lock[k]
          || err_o[k] !== m_err[k] || stuck_o[k] !== m_stuck[k]
          || cnt_o[k] !== 8'(m_cnt[k])) begin
        if (diverge[k] == 0)
          note[k] = $sformatf(
            "t=%0d edge %b/%b pv %b/%b hp %0d/%0d lock %b/%b err %b/%b stuck %b/%b cnt %0d/%0d",
            t, edge_o[k], m_edge[k], pv_o[k], m_pv[k], hp_o[k], m_hp[k],
            lock_o[k], m_lock[k], err_o[k], m_err[k], stuck_o[k], m_stuck[k],
            cnt_o[k], m_cnt[k]);
        diverge[k]++;
      end
    end
    div_in = d;
    cur = d;
    hist.push_back(d);
  endtask

  task automatic release_rst(input bit d);
    @(posedge clk);
    #1;
    rst = 1'b1;
    div_in = d;
    cur = d;
    model_reset();
    hist.push_back(d);
  endtask

  task automatic clear_div();
    for (int k = 0; k < 2; k++) begin
      diverge[k] = 0;
      note[k] = "";
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    div_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({edge_o[k], pv_o[k], lock_o[k], err_o[k], stuck_o[k], hp_o[k], cnt_o[k]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %b, want all zero", k,
                 {edge_o[k], pv_o[k], lock_o[k], err_o[k], stuck_o[k], hp_o[k], cnt_o[k]});
      end
    end
  endtask

  task automatic test_div2();
    int first_edge;
    int edges;
    int lock_at;
    int bad_hp;
    release_rst(1'b1);
    clear_div();
    first_edge = -1;
    edges = 0;
    lock_at = -1;
    bad_hp = 0;
    repeat (24) begin
      tick(~cur);
      if (edge_o[0]) begin
        edges++;
        if (first_edge < 0) first_edge = t;
      end
      if (lock_o[0] && lock_at < 0) lock_at = edges;
      if (pv_o[0] && hp_o[0] !== 8'd1) bad_hp++;
    end
    checks++;
    if (first_edge !== 3) begin
      errors++;
      $display("FAIL div2_first_edge: got cycle %0d, want 3", first_edge);
    end
    checks++;
    if (lock_at !== 5) begin
      errors++;
      $display("FAIL div2_lock_edge: got edge %0d, want 5", lock_at);
    end
    checks++;
    if (bad_hp !== 0) begin
      errors++;
      $display("FAIL div2_half_period: %0d periods not 1, want 0", bad_hp);
    end
    checks++;
    if (cnt_o[0] !== 8'd0) begin
      errors++;
      $display("FAIL div2_err_cnt: got %0d, want 0", cnt_o[0]);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (diverge[k] !== 0) begin
        errors++;
        $display("FAIL div2_model[%0d]: %0d cycles differ, want 0; first %s", k, diverge[k], note[k]);
      end
    end
  endtask

  task automatic test_hold3();
    int c0;
    int n_err;
    int err_hp;
    int edges_after;
    int relock;
    bit lock_low;
    clear_div();
    c0 = int'(cnt_o[0]);
    n_err = 0;
    err_hp = -1;
    edges_after = -1;
    relock = -1;
    lock_low = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick((i == 1 || i == 2) ? cur : ~cur);
      if (err_o[0]) begin
        n_err++;
        err_hp = int'(hp_o[0]);
        lock_low = !lock_o[0];
        edges_after = 0;
      end else if (edge_o[0] && edges_after >= 0) begin
        edges_after++;
      end
      if (lock_o[0] && edges_after >= 0 && relock < 0) relock = edges_after;
    end
    checks++;
    if (n_err !== 1) begin
      errors++;
      $display("FAIL hold3_err_count: got %0d, want 1", n_err);
    end
    checks++;
    if (err_hp !== 3) begin
      errors++;
      $display("FAIL hold3_half_period: got %0d, want 3", err_hp);
    end
    checks++;
    if (lock_low !== 1'b1) begin
      errors++;
      $display("FAIL hold3_lock_drop: locked still high with err");
    end
    checks++;
    if (cnt_o[0] !== 8'(c0 + 1)) begin
      errors++;
      $display("FAIL hold3_err_cnt: got %0d, want %0d", cnt_o[0], c0 + 1);
    end
    checks++;
    if (relock !== 4) begin
      errors++;
      $display("FAIL hold3_relock: relocked after %0d edges, want 4", relock);
    end
    checks++;
    if (diverge[0] !== 0) begin
      errors++;
      $display("FAIL hold3_model: %0d cycles differ, want 0; first %s", diverge[0], note[0]);
    end
  endtask

  task automatic test_stuck();
    int n_err;
    int first_pv;
    clear_div();
    n_err = 0;
    repeat (40) begin
      tick(cur);
      if (err_o[0]) n_err++;
    end
    checks++;
    if (n_err !== 1) begin
      errors++;
      $display("FAIL stuck_err_count: got %0d, want 1", n_err);
    end
    checks++;
    if (stuck_o[0] !== 1'b1 || lock_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL stuck_flags: stuck %b locked %b, want 1 0", stuck_o[0], lock_o[0]);
    end
    first_pv = -1;
    repeat (12) begin
      tick(~cur);
      if (edge_o[0] && first_pv < 0) first_pv = int'(pv_o[0]);
    end
    checks++;
    if (first_pv !== 0) begin
      errors++;
      $display("FAIL stuck_hunt_edge: period_valid %0d on first edge, want 0", first_pv);
    end
    checks++;
    if (stuck_o[0] !== 1'b0 || lock_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL stuck_relock: stuck %b locked %b, want 0 1", stuck_o[0], lock_o[0]);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (diverge[k] !== 0) begin
        errors++;
        $display("FAIL stuck_model[%0d]: %0d cycles differ, want 0; first %s", k, diverge[k], note[k]);
      end
    end
  endtask

  task automatic test_ratio4();
    int lens [10] = '{3, 5, 4, 6, 4, 4, 4, 4, 4, 4};
    int n_err;
    int err_hp;
    int pv_after;
    int lock_pv;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    release_rst(1'b0);
    clear_div();
    n_err = 0;
    err_hp = -1;
    pv_after = -1;
    lock_pv = -1;
    foreach (lens[h]) begin
      for (int j = 0; j < lens[h]; j++) begin
        tick(j == 0 ? ~cur : cur);
        if (err_o[1]) begin
          n_err++;
          err_hp = int'(hp_o[1]);
          pv_after = 0;
        end else if (pv_o[1] && pv_after >= 0) begin
          pv_after++;
        end
        if (lock_o[1] && lock_pv < 0) lock_pv = pv_after;
      end
    end
    checks++;
    if (n_err !== 1) begin
      errors++;
      $display("FAIL ratio4_err_count: got %0d, want 1", n_err);
    end
    checks++;
    if (err_hp !== 6) begin
      errors++;
      $display("FAIL ratio4_err_half: got %0d, want 6", err_hp);
    end
    checks++;
    if (lock_pv !== 4) begin
      errors++;
      $display("FAIL ratio4_match_reset: locked after %0d good halves, want 4", lock_pv);
    end
    checks++;
    if (diverge[1] !== 0) begin
      errors++;
      $display("FAIL ratio4_model: %0d cycles differ, want 0; first %s", diverge[1], note[1]);
    end
  endtask

  task automatic test_async_reset();
    int first_pv;
    repeat (10) tick(~cur);
    checks++;
    if (lock_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre_lock: locked %b, want 1", lock_o[0]);
    end
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({edge_o[k], pv_o[k], lock_o[k], err_o[k], stuck_o[k], hp_o[k], cnt_o[k]} !== '0) begin
        errors++;
        $display("FAIL areset_outputs[%0d]: got %b, want all zero", k,
                 {edge_o[k], pv_o[k], lock_o[k], err_o[k], stuck_o[k], hp_o[k], cnt_o[k]});
      end
    end
    repeat (2) @(posedge clk);
    release_rst(1'b1);
    clear_div();
    first_pv = -1;
    repeat (8) begin
      tick(~cur);
      if (edge_o[0] && first_pv < 0) first_pv = int'(pv_o[0]);
    end
    checks++;
    if (first_pv !== 0) begin
      errors++;
      $display("FAIL areset_first_edge: period_valid %0d, want 0", first_pv);
    end
    checks++;
    if (diverge[0] !== 0) begin
      errors++;
      $display("FAIL areset_model: %0d cycles differ, want 0; first %s", diverge[0], note[0]);
    end
  endtask

  task automatic test_random();
    int n;
    bit v;
    clear_div();
    repeat (80) begin
      if ($urandom_range(0, 9) == 0) n = $urandom_range(14, 24);
      else n = $urandom_range(1, 6);
      v = ~cur;
      repeat (n) tick(v);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (diverge[k] !== 0) begin
        errors++;
        $display("FAIL random_model[%0d]: %0d cycles differ, want 0; first %s", k, diverge[k], note[k]);
      end
    end
  endtask

  task automatic test_saturate();
    int n_err;
    bit v;
    clear_div();
    n_err = 0;
    repeat (275) begin
      v = ~cur;
      repeat (2) begin
        tick(v);
        if (err_o[0]) n_err++;
      end
    end
    checks++;
    if (n_err < 260) begin
      errors++;
      $display("FAIL sat_err_pulses: got %0d, want at least 260", n_err);
    end
    checks++;
    if (cnt_o[0] !== 8'd255) begin
      errors++;
      $display("FAIL sat_err_cnt: got %0d, want 255", cnt_o[0]);
    end
    checks++;
    if (diverge[0] !== 0) begin
      errors++;
      $display("FAIL sat_model: %0d cycles differ, want 0; first %s", diverge[0], note[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    clear_div();
    test_reset();
    test_div2();
    test_hold3();
    test_stuck();
    test_ratio4();
    test_async_reset();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_clock_checker.md
Name: div_clock_checker

Overview:
- Receive-side companion to the team's clock dividers: takes a divided clock (e.g. the divide-by-2 output) and checks it against the expected divide ratio.
- Measures every half-period in `clk` cycles, declares lock after N consecutive in-tolerance halves, and flags ratio or stuck errors.
- Sits beside any divider instance as a built-in self-check and a status source.

Parameters:
- EXP_HALF, 1, expected half-period in `clk` cycles (1 = divide-by-2).
- TOL, 0, allowed absolute deviation of a measured half-period from EXP_HALF.
- LOCK_CNT, 4, consecutive good halves required to assert `locked` (>=1).
- TIMEOUT, 16, cycles with no `div_in` edge before a stuck error (> EXP_HALF+TOL).
- CNT_W, 8, width of the run-length counter and `half_period`.
- SYNC_STAGES, 2, synchronizer flops on `div_in` (>=1).

Ports:
- clk  input  1  reference clock; the divider is sourced from it.
- rst  input  1  asynchronous, active-low reset.
- div_in  input  1  divided clock under test; sampled as data, never used as a clock.
- edge_pulse  output  1  one-cycle pulse per detected `div_in` toggle.
- half_period  output  CNT_W  last measured half-period in `clk` cycles.
- period_valid  output  1  one-cycle pulse when `half_period` updates.
- locked  output  1  level; ratio confirmed.
- err  output  1  one-cycle pulse on a bad half-period or a timeout.
- stuck  output  1  sticky; set on timeout, cleared when the checker next enters LOCKED.
- err_cnt  output  8  saturating count of `err` pulses.

Behaviour:
- Reset (`rst`=0, asynchronous): all outputs 0, synchronizer and `prev` flops 0, `run_len`=0, state HUNT, `match_cnt`=0.
- Synchronizer: `s` = `div_in` delayed by SYNC_STAGES flops. `prev` registers `s`. An edge is `s != prev`.
- Edge latency: `edge_pulse` rises SYNC_STAGES+1 cycles after the `div_in` transition. `period_valid`, `err` and the state update occur in that same cycle.
- Run-length counter:
  - Reloads to 1 on each edge.
  - Otherwise increments each cycle, saturating at 2^CNT_W-1.
  - On an edge, `half_period` <= `run_len` (the pre-reload value).
- Goodness test: a measured half is good when `half_period` is within EXP_HALF±TOL. The comparison uses CNT_W+1-bit arithmetic so it cannot underflow.
- FSM states HUNT, TRACK, LOCKED:
  - HUNT: the first edge moves to TRACK. That measurement is partial, so it is discarded: no `period_valid`, `half_period` is not updated, `match_cnt`=0.
  - TRACK, edge with a good half: `match_cnt`++. Reaching LOCK_CNT moves to LOCKED, sets `locked`=1, clears `stuck` and `match_cnt`.
  - TRACK, edge with a bad half: `err` pulse, `match_cnt`=0, stay in TRACK.
  - LOCKED, edge with a good half: stay in LOCKED.
  - LOCKED, edge with a bad half: `err` pulse, `locked`=0, go to TRACK with `match_cnt`=0.
  - Timeout (any state, `run_len`==TIMEOUT with no edge this cycle): `err` pulse, `stuck`=1, `locked`=0, go to HUNT. Fires once per stuck episode; HUNT suppresses repeats until an edge.
- Simultaneous edge and timeout: the edge wins and no timeout fires.
- `err_cnt` increments on every `err` pulse and holds at 255.
- `locked` drops in the same cycle as the bad-half or timeout `err` pulse.
- `rst` asserted mid-measurement: immediate return to reset values. The first post-reset edge is treated as partial (HUNT).
- Glitch shorter than one `clk` period on `div_in`: it is either missed or measured as a short half, which is a bad half (no special filter).

Decomposition:
- Shared package `clkdiv_pkg`:
  - state encoding localparams ST_HUNT=2'd0, ST_TRACK=2'd1, ST_LOCKED=2'd2;
  - default EXP_HALF/TOL constants shared with the divider blocks.
- Sub-module `sync_ff`: a parameterised SYNC_STAGES-deep flop chain with async active-low reset. It is reused by other cross-domain inputs in the codebase.
- FSM, counter and comparator stay in `div_clock_checker`.

Test Plan:
- Divide-by-2 stimulus (default params), `div_in` toggling every `clk` from reset release:
  - `edge_pulse` first at cycle 3 after the first toggle;
  - `half_period`=1 on every `period_valid`;
  - `locked`=1 on the 5th detected edge (1 HUNT edge + 4 good halves);
  - `err_cnt`=0.
- Locked at divide-by-2, then `div_in` held for 3 cycles once → one `err` pulse with `half_period`=3, `locked` drops, `err_cnt`=1, relocks after 4 further good halves.
- `div_in` held constant after lock → exactly one `err` pulse when `run_len`=16, `stuck`=1, state HUNT, no further `err`. Resume toggling → `stuck` clears on relock.
- EXP_HALF=4, TOL=1, halves 3,5,4,6 → `err` only on the 6, `match_cnt` resets there.
- Assert `rst` low mid-half while locked → all outputs 0 asynchronously. After release, the first edge produces no `period_valid`.
- Force `err` 260 times → `err_cnt` saturates at 255.
